// File: rtl/sar_adc_ctrl_if.sv
// sar_adc_ctrl_if: request/comparator/result bundle between the SAR
// control engine and its neighbours (AXI ADC interface and analog macro).
// NBITS must match the NBITS of the attached sar_adc_ctrl instance.
interface sar_adc_ctrl_if #(
    parameter int NBITS = 10
);
    logic             START;
    logic             CMP;
    logic             SAMPLE;
    logic [NBITS-1:0] DAC_CODE;
    logic             BUSY;
    logic [NBITS-1:0] DATA;
    logic             EOC;

    // Requester/analog side: issues START, returns the comparator decision.
    modport master (
        output START, CMP,
        input  SAMPLE, DAC_CODE, BUSY, DATA, EOC
    );

    // Control engine side.
    modport slave (
        input  START, CMP,
        output SAMPLE, DAC_CODE, BUSY, DATA, EOC
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation control engine for the on-chip ADC.
// Tracks the input for SAMPLE_CYCLES clocks, then resolves one result bit per
// step from MSB to LSB using a binary-search trial code on DAC_CODE.
// Optional feature macro: SAR_ADC_CMP_SYNC_EN -- when defined, CMP passes a
// two-flop synchronizer and each bit step lasts 3 clocks (settle + 2 sync).
module sar_adc_ctrl #(
    parameter int NBITS         = 10,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic           CLK,
    input  logic           RST,
    sar_adc_ctrl_if.slave  bus
);

    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CW-1:0]    TRACK_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [IW-1:0]    IDX_MSB    = IW'(NBITS - 1);
    localparam logic [NBITS-1:0] CODE_MSB   = NBITS'(1) << (NBITS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    track_cnt;
    logic [IW-1:0]    idx;
    logic [NBITS-1:0] result;
    logic [NBITS-1:0] dac_code;
    logic [NBITS-1:0] data;
    logic             sample;
    logic             busy;
    logic             eoc;

    // Comparator value used at a decision edge, and whether this edge is one.
    logic             cmp_use;
    logic             step_done;

`ifdef SAR_ADC_CMP_SYNC_EN
    logic       cmp_s1;
    logic       cmp_s2;
    logic [1:0] step_cnt;

    // Two-flop synchronizer on the asynchronous comparator output.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cmp_s1 <= 1'b0;
            cmp_s2 <= 1'b0;
        end else begin
            cmp_s1 <= bus.CMP;
            cmp_s2 <= cmp_s1;
        end
    end

    // Step counter: 0 = DAC settle, 1..2 = sync stages; decide when it reads 2.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            step_cnt <= 2'd0;
        end else if (state == CONVERT && step_cnt != 2'd2) begin
            step_cnt <= step_cnt + 2'd1;
        end else begin
            step_cnt <= 2'd0;
        end
    end

    assign cmp_use   = cmp_s2;
    assign step_done = (step_cnt == 2'd2);
`else
    assign cmp_use   = bus.CMP;
    assign step_done = 1'b1;
`endif

    logic [NBITS-1:0] result_nx;
    logic [IW-1:0]    idx_nx;
    logic [NBITS-1:0] dac_nx;

    // Next partial result and the trial code for the following bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        result_nx      = result;
        result_nx[idx] = cmp_use;
        idx_nx         = idx - IW'(1);
        dac_nx         = result_nx | (NBITS'(1) << idx_nx);
    end

    // Main control FSM: idle -> track -> bitwise convert -> idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state     <= IDLE;
            track_cnt <= '0;
            idx       <= '0;
            result    <= '0;
            dac_code  <= '0;
            data      <= '0;
            sample    <= 1'b0;
            busy      <= 1'b0;
            eoc       <= 1'b0;
        end else begin
            eoc <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state     <= TRACK;
                        busy      <= 1'b1;
                        sample    <= 1'b1;
                        track_cnt <= '0;
                    end
                end
                TRACK: begin
                    track_cnt <= track_cnt + CW'(1);
                    if (track_cnt == TRACK_LAST) begin
                        state    <= CONVERT;
                        sample   <= 1'b0;
                        result   <= '0;
                        idx      <= IDX_MSB;
                        dac_code <= CODE_MSB;
                    end
                end
                CONVERT: begin
                    if (step_done) begin
                        result <= result_nx;
                        if (idx != '0) begin
                            idx      <= idx_nx;
                            dac_code <= dac_nx;
                        end else begin
                            data     <= result_nx;
                            eoc      <= 1'b1;
                            busy     <= 1'b0;
                            dac_code <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SAMPLE   = sample;
    assign bus.DAC_CODE = dac_code;
    assign bus.BUSY     = busy;
    assign bus.DATA     = data;
    assign bus.EOC      = eoc;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed + randomized bench for sar_adc_ctrl with an
// ideal comparator (CMP = VIN >= DAC_CODE) and a binary-search reference.
// Honours SAR_ADC_CMP_SYNC_EN for the expected bit-step length.
module tb_sar_adc_ctrl;

    localparam int NB = 10;
    localparam int SC = 4;
`ifdef SAR_ADC_CMP_SYNC_EN
    localparam int S = 3;
`else
    localparam int S = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_adc_ctrl_if #(.NBITS(NB)) bus ();

    sar_adc_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [NB-1:0] vin;
    bit            rand_mode;
    logic          rand_cmp;

    assign bus.CMP = rand_mode ? rand_cmp : (vin >= bus.DAC_CODE);

    int passed = 0;
    int total  = 0;
    int failed = 0;

    int exp_trials[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Binary search over the code range: each trial sets the next bit below
    // the bits already decided; keep it if the input is at or above it.
    task automatic model(input int v, output int code);
        int trial;
        exp_trials.delete();
        code = 0;
        for (int b = NB - 1; b >= 0; b--) begin
            trial = code + (1 << b);
            exp_trials.push_back(trial);
            if (v >= trial) code = trial;
        end
    endtask

    // One conversion starting from a negedge; returns at the EOC negedge when
    // hold=1 (START left high), otherwise one cycle later with START low.
    task automatic do_conv(input int v, input bit hold, input bit poke, input string tag);
        int            code;
        int            n_sample;
        int            n_busy;
        int            n_bad;
        bit            done;
        logic [NB-1:0] seen[$];
        model(v, code);
        vin       = NB'(v);
        bus.START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_eoc_clear"}, 32'(bus.EOC), 0);
        check({tag, "_busy_rise"}, 32'(bus.BUSY), 1);
        n_sample = 0;
        n_busy   = 0;
        done     = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (bus.EOC) begin
                done = 1;
            end else begin
                if (bus.SAMPLE) n_sample++;
                if (bus.BUSY) n_busy++;
                if (bus.BUSY && !bus.SAMPLE) seen.push_back(bus.DAC_CODE);
                if (!hold) bus.START = poke ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
        end
        check({tag, "_eoc_seen"}, 32'(done), 1);
        if (!done) begin
            bus.START = 1'b0;
            return;
        end
        check({tag, "_sample_len"}, n_sample, SC);
        check({tag, "_busy_len"}, n_busy, SC + NB * S);
        check({tag, "_steps"}, seen.size(), NB * S);
        n_bad = 0;
        for (int i = 0; i < seen.size() && i < NB * S; i++)
            if (seen[i] !== NB'(exp_trials[i / S])) begin
                if (n_bad == 0)
                    check({tag, "_dac_code"}, 32'(seen[i]), exp_trials[i / S]);
                n_bad++;
            end
        check({tag, "_dac_bad_cnt"}, n_bad, 0);
        check({tag, "_busy_fall"}, 32'(bus.BUSY), 0);
        check({tag, "_data"}, 32'(bus.DATA), code);
        check({tag, "_data_vin"}, 32'(bus.DATA), v);
        check({tag, "_dac_idle"}, 32'(bus.DAC_CODE), 0);
        if (!hold) begin
            bus.START = 1'b0;
            @(negedge clk);
            check({tag, "_eoc_pulse"}, 32'(bus.EOC), 0);
            check({tag, "_data_hold"}, 32'(bus.DATA), code);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.BUSY), 0);
        check({tag, "_sample"}, 32'(bus.SAMPLE), 0);
        check({tag, "_eoc"}, 32'(bus.EOC), 0);
        check({tag, "_dac"}, 32'(bus.DAC_CODE), 0);
        check({tag, "_data"}, 32'(bus.DATA), 0);
    endtask

    initial begin
        int n_high;
        // 1. Reset with random inputs, then idle with START low.
        rst       = 1'b0;
        rand_mode = 1'b1;
        rand_cmp  = 1'b0;
        vin       = '0;
        bus.START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.START = 1'($urandom);
            rand_cmp  = 1'($urandom);
            check_all_zero("rst_hold");
        end
        @(negedge clk);
        bus.START = 1'b0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        n_high    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.BUSY) n_high++;
        end
        check("idle_busy_cycles", n_high, 0);
        check_all_zero("idle_after_rst");

        // 2. Reference conversion.
        do_conv('h2A5, 0, 0, "vin_2a5");

        // 3. Range ends.
        do_conv('h000, 0, 0, "vin_000");
        do_conv('h3FF, 0, 0, "vin_3ff");

        // 4. START held high back-to-back, then START chatter during BUSY.
        do_conv('h155, 1, 0, "b2b_155");
        do_conv('h0AA, 1, 0, "b2b_0aa");
        do_conv('h3FE, 0, 0, "b2b_3fe");
        for (int i = 0; i < 3; i++) begin
            do_conv(int'($urandom_range(0, (1 << NB) - 1)), 0, 1, "rand_poke");
            n_high = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus.BUSY) n_high++;
            end
            check("poke_no_restart", n_high, 0);
        end

        // 5. Reset 7 cycles into a conversion.
        do_conv('h3C1, 0, 0, "pre_rst");
        vin       = NB'('h2A5);
        bus.START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        check_all_zero("mid_rst_held");
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.BUSY), 0);
        do_conv('h123, 0, 0, "vin_123");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
